// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_pkg: types and helpers shared by the keypad matrix scanner.
//   state_t : scan FSM states
//   key_w() : width of the encoded key code for a ROWS x COLS matrix
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   function automatic int key_w(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: keypad pins plus the key-event outputs.
//   scan_en   : 1 = scanning runs, 0 = freeze
//   col_n     : active-low column sense lines (asynchronous)
//   row_n     : one-hot active-low row strobes
//   key_code  : row*COLS+col of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   key_held  : high from acceptance until release is accepted
// slave = scanner side, master = board/consumer side.
interface keypad_matrix_scanner_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   localparam int KW = keypad_pkg::key_w(ROWS, COLS);

   logic            scan_en;
   logic [COLS-1:0] col_n;
   logic [ROWS-1:0] row_n;
   logic [KW-1:0]   key_code;
   logic            key_valid;
   logic            key_held;

   modport slave  (input  scan_en, col_n,
                   output row_n, key_code, key_valid, key_held);
   modport master (output scan_en, col_n,
                   input  row_n, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_matrix_scanner_sync.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs.
//   i_clk : destination clock
//   i_rst : synchronous reset, active-high (flops reset to all 1 = idle pull-up level)
//   i_d   : asynchronous input
//   o_q   : synchronized output, 2 cycles latency
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: strobes one row low at a time, samples the
// synchronized active-low columns once per row dwell, debounces and
// reports one encoded key per press.
//   i_clk_div : system (divided) clock
//   i_rst     : synchronous reset, active-high
//   bus       : keypad_matrix_scanner_if.slave (scan_en, col_n in;
//               row_n, key_code, key_valid, key_held out)
// Parameters: ROWS, COLS matrix size; SETTLE cycles per row (>=3);
// DEBOUNCE consecutive matching samples to accept press/release (>=1).
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SETTLE   = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic                   i_clk_div,
   input  logic                   i_rst,
   keypad_matrix_scanner_if.slave bus
);
   localparam int KW  = key_w(ROWS, COLS);
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW  = $clog2(SETTLE);
   localparam int MW  = $clog2(DEBOUNCE + 1);

   logic [COLS-1:0] w_col_n;
   state_t          r_state, w_state_nxt;
   logic [DW-1:0]   r_dwell;
   logic [RW-1:0]   r_row;
   logic [CLW-1:0]  r_col, w_col_nxt, w_pcol;
   logic [MW-1:0]   r_cnt, w_cnt_nxt;
   logic [KW-1:0]   r_key_code;
   logic            r_key_valid;
   logic            w_sample, w_any, w_lat_low, w_accept, w_adv;

   sync_2ff #(.WIDTH(COLS)) u_sync (
      .i_clk (i_clk_div),
      .i_rst (i_rst),
      .i_d   (bus.col_n),
      .o_q   (w_col_n)
   );

   assign w_sample  = bus.scan_en && (r_dwell == DW'(SETTLE - 1));
   assign w_lat_low = ~w_col_n[r_col];

   // Lowest-index low column wins: scan downwards so the last hit is the lowest.
   always_comb begin
      w_any  = 1'b0;
      w_pcol = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (!w_col_n[c]) begin
            w_any  = 1'b1;
            w_pcol = CLW'(c);
         end
      end
   end

   // Next-state logic; everything moves only on a sample.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_col_nxt   = r_col;
      w_accept    = 1'b0;
      w_adv       = 1'b0;
      if (w_sample) begin
         case (r_state)
            ST_SCAN: begin
               if (w_any) begin
                  w_col_nxt = w_pcol;
                  if (DEBOUNCE == 1) begin
                     w_accept    = 1'b1;
                     w_state_nxt = ST_HELD;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt   = MW'(1);
                     w_state_nxt = ST_DEBOUNCE;
                  end
               end else begin
                  w_adv = 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (w_lat_low) begin
                  if (r_cnt == MW'(DEBOUNCE - 1)) begin
                     w_accept    = 1'b1;
                     w_state_nxt = ST_HELD;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end else begin
                  w_state_nxt = ST_SCAN;
                  w_cnt_nxt   = '0;
                  w_adv       = 1'b1;
               end
            end
            ST_HELD: begin
               // Count consecutive released samples; any low sample restarts.
               if (!w_lat_low) begin
                  if (r_cnt == MW'(DEBOUNCE - 1)) begin
                     w_state_nxt = ST_SCAN;
                     w_cnt_nxt   = '0;
                     w_adv       = 1'b1;
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end else begin
                  w_cnt_nxt = '0;
               end
            end
            default: w_state_nxt = ST_SCAN;
         endcase
      end
   end

   always_ff @(posedge i_clk_div) begin
      if (i_rst) begin
         r_state     <= ST_SCAN;
         r_dwell     <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_cnt       <= '0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
      end else begin
         r_key_valid <= w_accept;
         if (bus.scan_en) begin
            r_dwell <= (r_dwell == DW'(SETTLE - 1)) ? '0 : r_dwell + 1'b1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_col   <= w_col_nxt;
            if (w_adv)
               r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
            if (w_accept)
               r_key_code <= KW'(int'(r_row) * COLS + int'(w_col_nxt));
         end
      end
   end

   assign bus.row_n     = ~(ROWS'(1) << r_row);
   assign bus.key_code  = r_key_code;
   assign bus.key_valid = r_key_valid & bus.scan_en;
   assign bus.key_held  = (r_state == ST_HELD);
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner (4x4, SETTLE=4, DEBOUNCE=3).
// A combinational matrix model turns the pressed-key table into col_n
// from the DUT's row strobes.
module tb_keypad_matrix_scanner;
   localparam int ROWS = 4;
   localparam int COLS = 4;

   logic clk = 1'b0;
   logic rst;
   logic [ROWS-1:0][COLS-1:0] keys;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   kv_cnt = 0;

   always #5 clk = ~clk;

   keypad_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

   keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SETTLE(4), .DEBOUNCE(3)) dut (
      .i_clk_div (clk),
      .i_rst     (rst),
      .bus       (kif.slave)
   );

   // Key matrix: a pressed key pulls its column low while its row is strobed.
   always_comb begin
      kif.col_n = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (keys[r][c] && !kif.row_n[r]) kif.col_n[c] = 1'b0;
   end

   always begin
      @(posedge clk);
      #1;
      if (kif.key_valid) kv_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic wait_kv(input int target, input int budget, input string tag);
      int n = 0;
      while (kv_cnt < target && n < budget) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(kv_cnt >= target), 32'd1);
   endtask

   task automatic wait_held(input logic val, input int budget, input string tag);
      int n = 0;
      while (kif.key_held !== val && n < budget) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(kif.key_held), 32'(val));
   endtask

   initial begin
      logic [3:0] e;
      int kv0;
      rst         = 1'b1;
      keys        = '0;
      kif.scan_en = 1'b1;
      tick(3);
      chk("rst_row_n", 32'(kif.row_n), 32'hE);
      chk("rst_code",  32'(kif.key_code), 32'd0);
      chk("rst_valid", 32'(kif.key_valid), 32'd0);
      chk("rst_held",  32'(kif.key_held), 32'd0);

      // Idle: three full scans, each row strobed for 4 cycles.
      rst = 1'b0;
      for (int i = 0; i < 48; i++) begin
         e = ~(4'b0001 << ((i / 4) % 4));
         chk("idle_row_n", 32'(kif.row_n), 32'(e));
         tick(1);
      end
      chk("idle_no_kv", 32'(kv_cnt), 32'd0);

      // Exact latency: key row0 col3 down through reset; samples at 3,7,11.
      keys[0][3] = 1'b1;
      kv0 = kv_cnt;
      do_reset();
      for (int i = 1; i <= 13; i++) begin
         tick(1);
         if (i == 11) chk("lat_v11", 32'(kif.key_valid), 32'd0);
         if (i == 12) begin
            chk("lat_v12",  32'(kif.key_valid), 32'd1);
            chk("lat_code", 32'(kif.key_code), 32'd3);
            chk("lat_held", 32'(kif.key_held), 32'd1);
            chk("lat_row",  32'(kif.row_n), 32'hE);
         end
         if (i == 13) chk("lat_v13", 32'(kif.key_valid), 32'd0);
      end
      keys[0][3] = 1'b0;
      wait_held(1'b0, 40, "lat_release");

      // scan_en low for 50 cycles right after entering debounce.
      keys[0][1] = 1'b1;
      do_reset();
      tick(5);
      kv0 = kv_cnt;
      kif.scan_en = 1'b0;
      tick(50);
      chk("frz_row",  32'(kif.row_n), 32'hE);
      chk("frz_kv",   32'(kv_cnt), 32'(kv0));
      chk("frz_held", 32'(kif.key_held), 32'd0);
      kif.scan_en = 1'b1;
      tick(6);
      chk("frz_v6", 32'(kif.key_valid), 32'd0);
      tick(1);
      chk("frz_v7",   32'(kif.key_valid), 32'd1);
      chk("frz_code", 32'(kif.key_code), 32'd1);
      keys[0][1] = 1'b0;
      wait_held(1'b0, 40, "frz_release");

      // Clean press row2 col1 held 200 cycles.
      kv0 = kv_cnt;
      keys[2][1] = 1'b1;
      tick(200);
      chk("clean_kv",   32'(kv_cnt), 32'(kv0 + 1));
      chk("clean_code", 32'(kif.key_code), 32'd9);
      chk("clean_held", 32'(kif.key_held), 32'd1);
      keys[2][1] = 1'b0;
      tick(5);
      chk("clean_held_early", 32'(kif.key_held), 32'd1);
      wait_held(1'b0, 30, "clean_release");

      // Bounce row1 col3: toggling every 3 cycles never gives 3 low samples in a row.
      kv0 = kv_cnt;
      for (int k = 0; k < 40; k++) begin
         keys[1][3] = (((k / 3) % 2) == 0);
         tick(1);
      end
      chk("bnc_nopulse", 32'(kv_cnt), 32'(kv0));
      keys[1][3] = 1'b1;
      wait_kv(kv0 + 1, 60, "bnc_accept");
      chk("bnc_code", 32'(kif.key_code), 32'd7);
      keys[1][3] = 1'b0;
      wait_held(1'b0, 40, "bnc_release");

      // Two keys on row 0: lowest column wins, then col 2 after col 0 released.
      kv0 = kv_cnt;
      keys[0][2] = 1'b1;
      keys[0][0] = 1'b1;
      wait_kv(kv0 + 1, 60, "two_accept");
      chk("two_code0", 32'(kif.key_code), 32'd0);
      keys[0][0] = 1'b0;
      wait_held(1'b0, 40, "two_release0");
      wait_kv(kv0 + 2, 60, "two_accept2");
      chk("two_code2", 32'(kif.key_code), 32'd2);
      keys[0][2] = 1'b0;
      wait_held(1'b0, 40, "two_release2");

      // Reset while held; key is re-detected as a fresh press.
      kv0 = kv_cnt;
      keys[2][1] = 1'b1;
      wait_kv(kv0 + 1, 60, "rh_accept");
      chk("rh_held", 32'(kif.key_held), 32'd1);
      rst = 1'b1;
      tick(1);
      chk("rh_row",  32'(kif.row_n), 32'hE);
      chk("rh_held0", 32'(kif.key_held), 32'd0);
      chk("rh_code0", 32'(kif.key_code), 32'd0);
      rst = 1'b0;
      wait_kv(kv0 + 2, 100, "rh_reaccept");
      chk("rh_code", 32'(kif.key_code), 32'd9);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
